// File: rtl/hilo_muldiv_unit.sv
// Sequential WIDTH-bit multiply/divide unit with Hi/Lo result registers.
// Shift-add multiply / restoring divide, one bit per cycle, then a sign-fix cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             muldiv,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wrdata,
  output logic             busy,
  output logic             done,
  output logic             divbyzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  logic                 op_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 b_zero;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     rem;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       trial, diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, remr;
  logic                 last;

  assign mag_a = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign last  = (cnt == CW'(WIDTH - 1));

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

  // Divide: acc[WIDTH-1:0] shifts dividend out MSB first and quotient in LSB first;
  // the borrow of the 25-bit trial subtraction selects restore vs. keep.
  assign trial = {rem, acc[WIDTH-1]};
  assign diff  = trial - {1'b0, opnd};

  assign prod = neg_q ? (~acc + 1'b1) : acc;
  assign quot = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign remr = neg_r ? (~rem + 1'b1) : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      op_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      b_zero    <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      rem       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divbyzero <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mthi) hi <= wrdata;
          if (mtlo) lo <= wrdata;
          if (start) begin
            op_div    <= muldiv;
            neg_q     <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r     <= signed_op & a[WIDTH-1];
            b_zero    <= (b == '0);
            acc       <= {{WIDTH{1'b0}}, (muldiv ? mag_a : mag_b)};
            opnd      <= muldiv ? mag_b : mag_a;
            rem       <= '0;
            cnt       <= '0;
            divbyzero <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_div) begin
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH]};
            rem <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!op_div) begin
            {hi, lo} <= prod;
          end else if (b_zero) begin
            divbyzero <= 1'b1;
          end else begin
            lo <= quot;
            hi <= remr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: vector table plus corner-case sequences,
// with expected results queued at launch and compared when Done is observed.
module tb_hilo_muldiv_unit;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, muldiv = 1'b0, signed_op = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [W-1:0] a = '0, b = '0, wrdata = '0;
  logic busy, done, divbyzero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  typedef struct packed {
    logic         md;
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .muldiv(muldiv), .signed_op(signed_op),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wrdata(wrdata),
    .busy(busy), .done(done), .divbyzero(divbyzero), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the Start edge.
  task automatic launch(input logic md, input logic sg, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input exp_t e);
    start = 1'b1; muldiv = md; signed_op = sg; a = aa; b = bb;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Counts busy cycles until Done, then compares against the scoreboard head.
  task automatic wait_done(input string name, input int exp_busy);
    int   nb;
    bit   seen;
    exp_t e;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done never rose within 60 cycles, expected done=1", name);
    end else begin
      chki({name, " busy_cycles"}, nb, exp_busy);
      chk1({name, " busy_with_done"}, busy, 1'b0);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected done: actual=no pending op expected=pending op", name);
      end else begin
        e = sb.pop_front();
        chk({name, " hi"}, hi, e.hi);
        chk({name, " lo"}, lo, e.lo);
        chk1({name, " dbz"}, divbyzero, e.dbz);
      end
    end
  endtask

  initial begin
    vecs[0] = '{md:1'b0, sg:1'b0, a:24'hFFFFFF, b:24'hFFFFFF, hi:24'hFFFFFE, lo:24'h000001};
    vecs[1] = '{md:1'b0, sg:1'b1, a:24'hFFFFFD, b:24'h000005, hi:24'hFFFFFF, lo:24'hFFFFF1};
    vecs[2] = '{md:1'b1, sg:1'b0, a:24'd100,    b:24'd7,      hi:24'h000002, lo:24'h00000E};
    vecs[3] = '{md:1'b1, sg:1'b1, a:24'hFFFFF9, b:24'h000002, hi:24'hFFFFFF, lo:24'hFFFFFD};
    vecs[4] = '{md:1'b1, sg:1'b1, a:24'h800000, b:24'hFFFFFF, hi:24'h000000, lo:24'h800000};
    vecs[5] = '{md:1'b0, sg:1'b1, a:24'h800000, b:24'h800000, hi:24'h400000, lo:24'h000000};
    vecs[6] = '{md:1'b1, sg:1'b1, a:24'h000007, b:24'hFFFFFE, hi:24'h000001, lo:24'hFFFFFD};
    vecs[7] = '{md:1'b1, sg:1'b0, a:24'hFFFFF9, b:24'h000002, hi:24'h000001, lo:24'h7FFFFC};

    repeat (3) @(negedge clk);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk1("reset dbz", divbyzero, 1'b0);
    chk("reset hi", hi, '0);
    chk("reset lo", lo, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].md, vecs[i].sg, vecs[i].a, vecs[i].b, '{hi:vecs[i].hi, lo:vecs[i].lo, dbz:1'b0});
      wait_done($sformatf("vec%0d", i), 25);
      @(negedge clk);
      chk1($sformatf("vec%0d done_pulse", i), done, 1'b0);
    end

    // Moves, then divide by zero leaves Hi/Lo untouched.
    mthi = 1'b1; mtlo = 1'b1; wrdata = 24'h123456;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("move both hi", hi, 24'h123456);
    chk("move both lo", lo, 24'h123456);
    mtlo = 1'b1; wrdata = 24'h654321;
    @(negedge clk);
    mtlo = 1'b0;
    chk("move lo", lo, 24'h654321);
    chk("move lo keeps hi", hi, 24'h123456);
    launch(1'b1, 1'b0, 24'd5, 24'd0, '{hi:24'h123456, lo:24'h654321, dbz:1'b1});
    wait_done("div0", 25);
    @(negedge clk);
    chk1("div0 dbz held", divbyzero, 1'b1);

    // Start and MtLo while busy are ignored; back-to-back Start in Done cycle.
    launch(1'b1, 1'b0, 24'd100, 24'd7, '{hi:24'h000002, lo:24'h00000E, dbz:1'b0});
    chk1("dbz cleared on start", divbyzero, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1; muldiv = 1'b0; a = 24'd9; b = 24'd9; mtlo = 1'b1; wrdata = 24'hFFFFFF;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    chk("mtlo ignored while busy", lo, 24'h654321);
    wait_done("ignore", 19);
    launch(1'b0, 1'b0, 24'd3, 24'd4, '{hi:24'h000000, lo:24'h00000C, dbz:1'b0});
    chk1("b2b accepted busy", busy, 1'b1);
    wait_done("b2b", 25);
    @(negedge clk);

    // Reset in the middle of RUN aborts and clears.
    mthi = 1'b1; wrdata = 24'hABCDEF;
    @(negedge clk);
    mthi = 1'b0;
    chk("pre-reset hi", hi, 24'hABCDEF);
    launch(1'b0, 1'b0, 24'd5, 24'd6, '{hi:24'h0, lo:24'd30, dbz:1'b0});
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk1("midreset busy", busy, 1'b0);
    chk1("midreset done", done, 1'b0);
    chk1("midreset dbz", divbyzero, 1'b0);
    chk("midreset hi", hi, '0);
    chk("midreset lo", lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      chk1("no done after abort", done, 1'b0);
    end
    launch(1'b0, 1'b0, 24'd3, 24'd4, '{hi:24'h000000, lo:24'h00000C, dbz:1'b0});
    wait_done("post-reset", 25);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Sequential 24-bit multiply/divide unit beside the 24-bit ALU in the single-cycle CPU datapath. It takes the same A/B operands the ALU sees and iterates one bit per cycle. It writes a 48-bit product, or a quotient/remainder pair, into dedicated Hi/Lo registers, which the writeback path reads. The control unit stalls on Busy and may write Hi/Lo directly for move-to-Hi/Lo instructions.

## Interface
Parameters:
- WIDTH, 24, operand and Hi/Lo register width; iteration count equals WIDTH.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low; clears all state.
- Start  input  1  launch request; honoured only in IDLE.
- MulDiv  input  1  0 = multiply, 1 = divide; sampled with Start.
- Signed  input  1  1 = two's-complement operands; sampled with Start.
- A  input  24  multiplicand / dividend.
- B  input  24  multiplier / divisor.
- MtHi  input  1  write WrData into Hi; honoured only in IDLE.
- MtLo  input  1  write WrData into Lo; honoured only in IDLE.
- WrData  input  24  data for MtHi/MtLo.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result.
- DivByZero  output  1  last divide had B == 0; held until the next accepted Start.
- Hi  output  24  high product half / remainder.
- Lo  output  24  low product half / quotient.

## Operation
- States: IDLE, RUN, FIX. The implementation needs a 5-bit iteration counter.
- IDLE:
  - On Start, capture MulDiv, Signed, and the operand magnitudes.
  - When Signed=1, take the magnitude of a negative operand by 2's-complement negation.
  - Record the result signs: product/quotient sign = A[23]^B[23]; remainder sign = A[23].
  - Clear DivByZero, zero the counter, and go to RUN.
- RUN, multiply: shift-add on a 48-bit accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first, with a 25-bit partial remainder.
- RUN exits to FIX after exactly WIDTH cycles.
- FIX, multiply: apply the sign, then {Hi,Lo} = 48-bit product.
- FIX, divide: apply signs, then Lo = quotient and Hi = remainder.
- FIX pulses Done and returns to IDLE.
- Divide with B == 0 (captured value):
  - Iterations still run; latency is unchanged.
  - In FIX, Hi/Lo are not written and DivByZero is set.
- Signed -2^23 / -1: quotient wraps; Lo = 0x800000, Hi = 0x000000.
- Unsigned mode: operands are taken as-is, with no sign fix.
- MtHi/MtLo in IDLE write WrData on that edge. When both are asserted, both registers are written.
- Start, MtHi, and MtLo are ignored outside IDLE. There is no queuing.
- Start together with MtHi/MtLo in IDLE: the move writes on that edge and Start is also accepted; the later result overwrites the moved value.
- A/B may change after the Start edge without effect.

## Timing
- Reset values: Busy=0, Done=0, DivByZero=0, Hi=0x000000, Lo=0x000000, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately. Hi/Lo are cleared and no Done is produced.
- Start is sampled on edge E0.
- Busy is high after E0 and stays high through RUN (E1..E24) and the FIX cycle.
- Edge E25 loads Hi/Lo. From E25 to E26: Busy=0 and Done=1; Hi, Lo, and DivByZero are valid.
- Total latency is 25 cycles, Start edge to result edge.
- A new Start may be presented in the Done cycle and is accepted at E26.
- Busy and Done are never high together.
- Hi/Lo are stable except on a FIX edge, a Move edge, or reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Unsigned multiply 0xFFFFFF × 0xFFFFFF -> after 25 cycles: Done=1, Hi=0xFFFFFE, Lo=0x000001; Busy high for exactly 25 cycles.
- Signed multiply 0xFFFFFD (-3) × 0x000005 -> Hi=0xFFFFFF, Lo=0xFFFFF1.
- Divides:
  - unsigned 100/7 -> Lo=0x00000E, Hi=0x000002;
  - signed 0xFFFFF9 (-7) / 2 -> Lo=0xFFFFFD, Hi=0xFFFFFF;
  - signed 0x800000 / 0xFFFFFF -> Lo=0x800000, Hi=0x000000.
- Divide by zero: first MtHi=0x123456 and MtLo=0x654321 in the same cycle (both written); then divide 5/0 -> Done after 25 cycles, DivByZero=1, Hi/Lo unchanged.
- While Busy, pulse Start (different operands) and MtLo -> both ignored; the original result is delivered. Back-to-back Start in the Done cycle is accepted.
- Assert Reset at RUN iteration 10 -> all outputs 0 immediately. After release, Start 3×4 unsigned -> Lo=0x00000C, Hi=0.
